// File: rtl/seg_message_scroller_if.sv
// seg_message_scroller_if
//   Bundles the scroller's user-side signals: button, mode/direction
//   controls, the message write port and the display outputs.
//   master : drives the controls and the write port, reads the display.
//   slave  : the scroller itself.
//   Signals
//     step_in   raw asynchronous button
//     mode      0 = manual stepping, 1 = auto-scroll
//     dir       0 = forward, 1 = reverse
//     load_we   message write strobe
//     load_addr message write index
//     load_data segment code (bit7 = dp, bits[6:0] = a..g)
//     seg_out   registered segment code of the active digit
//     digit_en  registered one-hot digit enable
//     pos_out   current window start index
//     running   high while auto-scroll is running
interface seg_message_scroller_if #(
    parameter int MSG_LEN = 14,
    parameter int DIGITS  = 4,
    parameter int AW      = $clog2(MSG_LEN)
);
    logic              step_in;
    logic              mode;
    logic              dir;
    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [7:0]        load_data;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] digit_en;
    logic [AW-1:0]     pos_out;
    logic              running;

    modport master (
        output step_in, mode, dir, load_we, load_addr, load_data,
        input  seg_out, digit_en, pos_out, running
    );

    modport slave (
        input  step_in, mode, dir, load_we, load_addr, load_data,
        output seg_out, digit_en, pos_out, running
    );
endinterface

// File: rtl/seg_message_scroller.sv
// seg_message_scroller
//   Holds a writable message of MSG_LEN segment codes and shows a
//   DIGITS-wide window of it on a multiplexed 7-segment display. The window
//   steps on a debounced button press (manual) or on an internal timer
//   (auto-scroll, pausable by the button), forward or reverse.
//   Ports
//     clk  single clock, everything changes on its rising edge
//     rst  asynchronous active-high reset
//     bus  seg_message_scroller_if.slave (controls, write port, display)
module seg_message_scroller #(
    parameter int MSG_LEN         = 14,
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCROLL_DIV      = 1000000,
    parameter int AW              = $clog2(MSG_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    seg_message_scroller_if.slave  bus
);

    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int IW = AW + 4;   // room for pos + sel before the wrap

    typedef enum logic [1:0] {
        MANUAL,
        AUTO_RUN,
        AUTO_PAUSED
    } state_t;

    // Power-on message "SEnOLGULGOnUL"; entries past it are blank.
    function automatic logic [7:0] init_entry(input int i);
        case (i)
            0:       return 8'h5B;
            1:       return 8'h4F;
            2:       return 8'h15;
            3:       return 8'h7E;
            4:       return 8'h0E;
            5:       return 8'h5F;
            6:       return 8'h3E;
            7:       return 8'h0E;
            8:       return 8'h5F;
            9:       return 8'h7E;
            10:      return 8'h15;
            11:      return 8'h3E;
            12:      return 8'h0E;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [AW-1:0] next_pos(input logic [AW-1:0] p,
                                               input logic          rev);
        if (!rev)
            return (p == AW'(MSG_LEN - 1)) ? '0 : p + 1'b1;
        else
            return (p == '0) ? AW'(MSG_LEN - 1) : p - 1'b1;
    endfunction

    logic              step_sync_p0, step_sync_p1;
    logic              db_level;
    logic [CW-1:0]     db_cnt;
    logic              step_pulse;
    state_t            state_q, state_d;
    logic [DW-1:0]     scnt_q, scnt_d;
    logic              advance;
    logic [AW-1:0]     pos_q;
    logic [SW-1:0]     sel_q;
    logic [7:0]        msg [MSG_LEN];
    logic [IW-1:0]     rd_sum;
    logic [AW-1:0]     rd_idx;
    logic              addr_ok;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] digit_en_q;

    // ---- stage p0/p1: button synchroniser ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync_p0 <= 1'b0;
            step_sync_p1 <= 1'b0;
        end else begin
            step_sync_p0 <= bus.step_in;
            step_sync_p1 <= step_sync_p0;
        end
    end

    // ---- debounce and rising-edge pulse ----
    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle;
    // the pulse is registered alongside so it lands exactly one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level   <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else if (step_sync_p1 != db_level) begin
            if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_level   <= step_sync_p1;
                db_cnt     <= '0;
                step_pulse <= step_sync_p1;
            end else begin
                db_cnt     <= db_cnt + 1'b1;
                step_pulse <= 1'b0;
            end
        end else begin
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end
    end

    // ---- mode state machine and scroll timer ----
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        advance = 1'b0;
        case (state_q)
            MANUAL: begin
                if (bus.mode) begin
                    // A step coinciding with entry is swallowed here.
                    state_d = AUTO_RUN;
                    scnt_d  = '0;
                end else if (step_pulse) begin
                    advance = 1'b1;
                end
            end
            AUTO_RUN: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (step_pulse) begin
                    state_d = AUTO_PAUSED;
                end else if (scnt_q == DW'(SCROLL_DIV - 1)) begin
                    scnt_d  = '0;
                    advance = 1'b1;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            AUTO_PAUSED: begin
                if (!bus.mode)
                    state_d = MANUAL;
                else if (step_pulse)
                    state_d = AUTO_RUN;
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MANUAL;
            scnt_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            if (advance)
                pos_q <= next_pos(pos_q, bus.dir);
        end
    end

    // ---- message RAM ----
    // Widened compare so a power-of-two MSG_LEN does not truncate to zero.
    assign addr_ok = ({1'b0, bus.load_addr} < (AW + 1)'(MSG_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++)
                msg[i] <= init_entry(i);
        end else if (bus.load_we && addr_ok) begin
            msg[bus.load_addr] <= bus.load_data;
        end
    end

    // ---- display mux: (pos + sel) mod MSG_LEN by a single subtract ----
    always_comb begin
        rd_sum = IW'(pos_q) + IW'(sel_q);
        rd_idx = (rd_sum >= IW'(MSG_LEN)) ? AW'(rd_sum - IW'(MSG_LEN))
                                          : AW'(rd_sum);
    end

    // ---- output stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            seg_q      <= 8'h00;
            digit_en_q <= '0;
        end else begin
            sel_q      <= (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
            digit_en_q <= DIGITS'(1) << sel_q;
            seg_q      <= msg[rd_idx];
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.digit_en = digit_en_q;
    assign bus.pos_out  = pos_q;
    assign bus.running  = (state_q == AUTO_RUN);

endmodule

// File: tb/tb_seg_message_scroller.sv
module tb_seg_message_scroller;

    localparam int MSG_LEN = 14;
    localparam int DIGITS  = 4;
    localparam int DEB     = 16;
    localparam int DIV     = 8;
    localparam int AW      = $clog2(MSG_LEN);
    localparam int LAT     = 2 + DEB + 1;   // button edge -> pos change

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_message_scroller_if #(.MSG_LEN(MSG_LEN), .DIGITS(DIGITS)) bus ();

    seg_message_scroller #(
        .MSG_LEN(MSG_LEN), .DIGITS(DIGITS),
        .DEBOUNCE_CYCLES(DEB), .SCROLL_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;      // edges since reset release
    logic [7:0] msg_m [MSG_LEN];
    int         pos_m;
    bit         run_m;
    int         runcnt;          // edges spent staying in auto-run

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_model();
        logic [7:0] init [13];
        init = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E,
                 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};
        for (int i = 0; i < MSG_LEN; i++)
            msg_m[i] = (i < 13) ? init[i] : 8'h00;
        pos_m  = 0;
        run_m  = 1'b0;
        runcnt = 0;
    endtask

    function automatic int moved(input int p, input bit rev);
        return rev ? (p + MSG_LEN - 1) % MSG_LEN : (p + 1) % MSG_LEN;
    endfunction

    // Digit select is simply the edge count since reset, modulo DIGITS.
    task automatic check_window(input string tag);
        for (int i = 0; i < DIGITS; i++) begin
            int d;
            tick();
            d = (cyc - 1) % DIGITS;
            chk({tag, "_digit_en"}, 32'(bus.digit_en), 32'(1 << d));
            chk({tag, "_seg"}, 32'(bus.seg_out), 32'(msg_m[(pos_m + d) % MSG_LEN]));
        end
    endtask

    task automatic press_manual(input bit rev, input int hold, input int gap);
        bus.dir     = rev;
        bus.step_in = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (k == LAT) pos_m = moved(pos_m, rev);
            chk("press_pos", 32'(bus.pos_out), 32'(pos_m));
        end
        bus.step_in = 1'b0;
        for (int k = 0; k < gap; k++) tick();
        chk("release_pos", 32'(bus.pos_out), 32'(pos_m));
    endtask

    // One auto-mode edge: the window advances on every DIV-th edge that
    // begins and ends in the running state.
    task automatic auto_tick(input bit run_after);
        bit prev;
        prev = run_m;
        tick();
        run_m = run_after;
        if (prev && run_m) begin
            runcnt++;
            if (runcnt % DIV == 0) pos_m = moved(pos_m, bus.dir);
        end
        chk("auto_running", 32'(bus.running), 32'(run_m));
        chk("auto_pos", 32'(bus.pos_out), 32'(pos_m));
    endtask

    // Button press that toggles run/pause: the toggle lands LAT edges in.
    task automatic auto_press(input bit run_before);
        bus.step_in = 1'b1;
        for (int k = 1; k < LAT; k++) auto_tick(run_before);
        auto_tick(!run_before);
        for (int k = 0; k < 6; k++) auto_tick(!run_before);
        bus.step_in = 1'b0;
        for (int k = 0; k < 25; k++) auto_tick(!run_before);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  found;
        logic [7:0] d8;

        bus.step_in   = 1'b0;
        bus.mode      = 1'b0;
        bus.dir       = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = 8'h00;
        reset_model();

        // Reset and default window
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
        chk("rst_seg", 32'(bus.seg_out), 32'h00);
        chk("rst_digit_en", 32'(bus.digit_en), 32'h0);
        chk("rst_pos", 32'(bus.pos_out), 32'h0);
        chk("rst_running", 32'(bus.running), 32'h0);
        check_window("reset_win");

        // Short bounces never get through the debouncer
        for (int b = 0; b < 4; b++) begin
            bus.step_in = 1'b1;
            repeat (5) tick();
            bus.step_in = 1'b0;
            repeat (5) tick();
            chk("bounce_pos", 32'(bus.pos_out), 32'h0);
        end
        repeat (20) tick();

        // Long press: exact latency, and no step on release
        press_manual(1'b0, 40, 30);
        chk("latency_pos", 32'(bus.pos_out), 32'h1);

        // Forward wrap back to 0, then reverse wrap to MSG_LEN-1
        while (pos_m != 0)
            press_manual(1'b0, $urandom_range(20, 30), $urandom_range(20, 30));
        chk("fwd_wrap_pos", 32'(bus.pos_out), 32'h0);
        press_manual(1'b1, 25, 22);
        chk("rev_wrap_pos", 32'(bus.pos_out), 32'(MSG_LEN - 1));
        check_window("wrap_win");

        // Random manual presses
        for (int r = 0; r < 6; r++) begin
            press_manual(1'($urandom_range(0, 1)), $urandom_range(20, 30),
                         $urandom_range(20, 30));
            check_window("rand_win");
        end
        while (pos_m != 0) press_manual(1'b0, 20, 20);

        // Loads: in-range visible, out-of-range ignored
        bus.load_we   = 1'b1;
        bus.load_addr = AW'(2);
        bus.load_data = 8'h76;
        tick();
        msg_m[2] = 8'h76;
        bus.load_we = 1'b0;
        check_window("load_win");
        check_window("load_win2");
        bus.load_we   = 1'b1;
        bus.load_addr = AW'(15);
        bus.load_data = 8'($urandom);
        tick();
        bus.load_we = 1'b0;
        check_window("oob_win");
        for (int r = 0; r < 3; r++) begin
            int a;
            a = $urandom_range(0, 2);
            if (a == 2) a = 3;
            d8 = 8'($urandom);
            bus.load_we   = 1'b1;
            bus.load_addr = AW'(a);
            bus.load_data = d8;
            tick();
            msg_m[a] = d8;
            bus.load_we = 1'b0;
            check_window("rand_load_win");
        end

        // Auto-scroll with pause/resume at a random moment
        bus.dir  = 1'($urandom_range(0, 1));
        bus.mode = 1'b1;
        auto_tick(1'b1);
        for (int k = 0; k < 20; k++) auto_tick(1'b1);
        for (int k = 0; k < int'($urandom_range(0, 15)); k++) auto_tick(1'b1);
        auto_press(1'b1);
        auto_press(1'b0);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (pos_m == 7) found = 1;
            else auto_tick(1'b1);
        end
        chk("auto_reach_7", 32'(found), 32'h1);

        // Asynchronous reset in the middle of auto-run
        #2;
        rst      = 1'b1;
        bus.mode = 1'b0;
        #1;
        chk("async_rst_seg", 32'(bus.seg_out), 32'h00);
        chk("async_rst_digit_en", 32'(bus.digit_en), 32'h0);
        chk("async_rst_pos", 32'(bus.pos_out), 32'h0);
        chk("async_rst_running", 32'(bus.running), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        cyc = 0;
        reset_model();
        check_window("post_rst_win");
        chk("post_rst_running", 32'(bus.running), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_message_scroller.md
# seg_message_scroller

Parametrised 7-segment message scroller for the TinyTapeout user tile. It holds a writable message of `MSG_LEN` segment codes and shows a `DIGITS`-wide window of it on a multiplexed display. The window steps by a debounced button or by an internal auto-scroll timer, in either direction. It replaces the single-digit, button-clocked letter stepper: all logic runs on `clk`, and the button is only sampled.

## Interface
Parameters:
- `MSG_LEN`, 14: message entries; minimum 2.
- `DIGITS`, 4: display digits; 1..8.
- `DEBOUNCE_CYCLES`, 16: stable cycles required to accept a new button level.
- `SCROLL_DIV`, 1000000: clock cycles per auto-scroll step.
- `AW`, `$clog2(MSG_LEN)`: address width; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `step_in`  in  1  raw, asynchronous, bouncy button.
- `mode`  in  1  0 = manual stepping, 1 = auto-scroll.
- `dir`  in  1  0 = forward (+1), 1 = reverse (−1).
- `load_we`  in  1  message write strobe.
- `load_addr`  in  AW  message write index.
- `load_data`  in  8  segment code, bit7 = dp, bits[6:0] = a..g.
- `seg_out`  out  8  registered segment code for the active digit.
- `digit_en`  out  DIGITS  registered one-hot digit enable, active-high.
- `pos_out`  out  AW  current window start index.
- `running`  out  1  high while in AUTO_RUN.

## Operation
- **Reset** sets:
  - `seg_out` = 0x00, `digit_en` = 0, `pos_out` = 0, `running` = 0.
  - Mux digit select = 0; state = MANUAL; all counters = 0.
  - Message RAM entries 0..12 = 5B,4F,15,7E,0E,5F,3E,0E,5F,7E,15,3E,0E ("SEnOLGULGOnUL"); all other entries = 0x00. Only entries below `MSG_LEN` exist.
- **Input conditioning:** `step_in` passes through a 2-FF synchroniser. The debounced level changes only after the synchronised value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. A 0→1 change of the debounced level produces a one-cycle `step` pulse.
- **State machine** (states MANUAL, AUTO_RUN, AUTO_PAUSED):
  - `mode` = 0 in any state → MANUAL.
  - MANUAL with `mode` = 1 → AUTO_RUN, and the scroll counter clears.
  - AUTO_RUN with `step` → AUTO_PAUSED.
  - AUTO_PAUSED with `step` → AUTO_RUN; the scroll counter is not cleared.
- **Advance:**
  - In MANUAL, `step` advances the position.
  - In AUTO_RUN, the scroll counter counts 0..`SCROLL_DIV`−1; at the terminal count it wraps to 0 and advances the position.
  - In AUTO_PAUSED the scroll counter holds.
- **Position arithmetic:**
  - `dir` = 0: `pos` = `MSG_LEN`−1 → 0, otherwise `pos`+1.
  - `dir` = 1: `pos` = 0 → `MSG_LEN`−1, otherwise `pos`−1.
  - `dir` is sampled in the advance cycle.
- **Display:**
  - The digit select increments every cycle and wraps `DIGITS`−1 → 0.
  - Each cycle: `digit_en` <= onehot(sel); `seg_out` <= msg[(pos+sel) mod `MSG_LEN`]. The modulo is computed without a divider (compare and subtract once).
  - Digit 0 is the leftmost.
- **Load:**
  - `load_we` with `load_addr` < `MSG_LEN` writes `load_data`.
  - An out-of-range address is ignored.
  - A write and an advance in the same cycle both take effect.

## Timing
- `seg_out`/`digit_en` lag the digit select and the RAM read by 1 cycle. The first non-zero `digit_en` (= 1) appears on the first edge after reset release.
- Step latency: button edge → `pos_out` change = 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. `seg_out` reflects the new `pos` 1 cycle later.
- A RAM write is visible on `seg_out` 1 cycle after the write edge, at the next selection of that digit.
- `mode` changes take effect on the next edge.
- A step arriving in the same cycle as a `mode` 0→1 transition is consumed by the transition; the position does not advance.
- An asynchronous `rst` mid-scroll or mid-bounce clears everything immediately. The debounced level resets to 0, so a button held through reset produces a step only after release and re-press.

## Test plan
- **Reset/default:** assert `rst`, release; with `DIGITS` = 4, over 4 cycles expect `digit_en` 1,2,4,8 with `seg_out` 5B,4F,15,7E; `pos_out` = 0.
- **Debounce:** pulses of 5 cycles (`DEBOUNCE_CYCLES` = 16) → no change; then a 40-cycle press → `pos_out` = 1 exactly 19 cycles after press; release → no further step.
- **Wrap both ways:** manual, `dir` = 0, 14 presses → `pos_out` back to 0; `dir` = 1, one press → `pos_out` = 13; the window then shows entries 13,0,1,2 = 00,5B,4F,15.
- **Auto/pause:** `SCROLL_DIV` = 8, `mode` = 1 → `pos_out` increments every 8 cycles and `running` = 1; a press → `running` = 0 and `pos` frozen; a second press → resumes, with the residual count preserved.
- **Load:** write 0x76 to address 2 while displaying → the next digit-2 slot shows 76; a write to address 15 (`MSG_LEN` = 14) leaves the RAM unchanged.
- **Reset mid-operation:** `rst` during AUTO_RUN with `pos` = 7 → all outputs at reset values asynchronously, state MANUAL, entry 2 restored to 15.
